sdram_arbiter: RTL and testbench

Three-port arbiter that shares the single SDRAM controller (256-bit burst interface, 21-bit line address) between the instruction cache, the data cache and the DMA/GPU fetch engine. Each requester issues a one-cycle start pulse with address, data and write-enable. The arbiter latches the request, grants the controller round-robin, and returns a one-cycle done pulse with registered read data to the owning port. It sits between the cache/DMA blocks and the SDRAM controller, in the same clock domain.

---
 rtl/sdram_arbiter_if.sv | 62 ++++++
 rtl/sdram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if
// Bundles the three requester ports (0 = instruction cache, 1 = data cache,
// 2 = DMA/GPU fetch) and the SDRAM controller side of the arbiter.
//   pN_addr/data/we/start : request from port N (sampled on pN_start)
//   pN_done/q/busy        : completion pulse, registered read data, pending flag
//   ctrl_addr/data/we/start : command towards the SDRAM controller
//   ctrl_done/q             : completion and read data from the controller
// The arbiter uses the slave modport; the requesters/controller use master.
interface sdram_arbiter_if;
  logic [20:0]  p0_addr;
  logic [255:0] p0_data;
  logic         p0_we;
  logic         p0_start;
  logic         p0_done;
  logic [255:0] p0_q;
  logic         p0_busy;

  logic [20:0]  p1_addr;
  logic [255:0] p1_data;
  logic         p1_we;
  logic         p1_start;
  logic         p1_done;
  logic [255:0] p1_q;
  logic         p1_busy;

  logic [20:0]  p2_addr;
  logic [255:0] p2_data;
  logic         p2_we;
  logic         p2_start;
  logic         p2_done;
  logic [255:0] p2_q;
  logic         p2_busy;

  logic [20:0]  ctrl_addr;
  logic [255:0] ctrl_data;
  logic         ctrl_we;
  logic         ctrl_start;
  logic         ctrl_done;
  logic [255:0] ctrl_q;

  modport slave (
    input  p0_addr, p0_data, p0_we, p0_start,
    input  p1_addr, p1_data, p1_we, p1_start,
    input  p2_addr, p2_data, p2_we, p2_start,
    output p0_done, p0_q, p0_busy,
    output p1_done, p1_q, p1_busy,
    output p2_done, p2_q, p2_busy,
    output ctrl_addr, ctrl_data, ctrl_we, ctrl_start,
    input  ctrl_done, ctrl_q
  );

  modport master (
    output p0_addr, p0_data, p0_we, p0_start,
    output p1_addr, p1_data, p1_we, p1_start,
    output p2_addr, p2_data, p2_we, p2_start,
    input  p0_done, p0_q, p0_busy,
    input  p1_done, p1_q, p1_busy,
    input  p2_done, p2_q, p2_busy,
    input  ctrl_addr, ctrl_data, ctrl_we, ctrl_start,
    output ctrl_done, ctrl_q
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares one SDRAM controller between three requesters. Each port latches a
// single outstanding request; the arbiter grants round-robin, issues a
// one-cycle ctrl_start, waits for ctrl_done and returns a one-cycle pN_done
// with registered read data to the owning port.
// Ports:
//   clk   : system / SDRAM controller clock
//   reset : asynchronous, active-low
//   bus   : sdram_arbiter_if.slave (requester ports and controller command)
module sdram_arbiter (
  input  logic           clk,
  input  logic           reset,
  sdram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t       state_reg, state_next;

  logic [2:0]   start_in;
  logic [20:0]  addr_in [3];
  logic [255:0] data_in [3];
  logic [2:0]   we_in;

  logic [2:0]   pending_vec;
  logic [2:0]   done_vec;
  logic [2:0]   req_we;
  logic [20:0]  req_addr [3];
  logic [255:0] req_data [3];
  logic [255:0] q_out [3];

  logic [1:0]   grant_reg, last_grant_reg;
  logic [1:0]   cand1, cand2, win;
  logic         win_valid, issue, complete;

  logic [20:0]  ctrl_addr_reg;
  logic [255:0] ctrl_data_reg;
  logic         ctrl_we_reg, ctrl_start_reg;

  assign start_in   = {bus.p2_start, bus.p1_start, bus.p0_start};
  assign we_in      = {bus.p2_we, bus.p1_we, bus.p0_we};
  assign addr_in[0] = bus.p0_addr;
  assign addr_in[1] = bus.p1_addr;
  assign addr_in[2] = bus.p2_addr;
  assign data_in[0] = bus.p0_data;
  assign data_in[1] = bus.p1_data;
  assign data_in[2] = bus.p2_data;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Round-robin pick: search starts just after the last granted port, and the
  // last granted port itself is considered only after the other two.
  always_comb begin
    cand1     = next_port(last_grant_reg);
    cand2     = next_port(cand1);
    win       = last_grant_reg;
    win_valid = 1'b0;
    if (pending_vec[cand1]) begin
      win       = cand1;
      win_valid = 1'b1;
    end else if (pending_vec[cand2]) begin
      win       = cand2;
      win_valid = 1'b1;
    end else if (pending_vec[last_grant_reg]) begin
      win_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // ctrl_done outside ST_WAIT is ignored simply by not being looked at.
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (win_valid) begin
          issue      = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (bus.ctrl_done) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Command registers stay loaded through WAIT so the controller sees a
  // stable address/data for the whole burst.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_addr_reg  <= '0;
      ctrl_data_reg  <= '0;
      ctrl_we_reg    <= 1'b0;
      ctrl_start_reg <= 1'b0;
      grant_reg      <= 2'd0;
      last_grant_reg <= 2'd2;
    end else begin
      ctrl_start_reg <= issue;
      if (issue) begin
        ctrl_addr_reg  <= req_addr[win];
        ctrl_data_reg  <= req_data[win];
        ctrl_we_reg    <= req_we[win];
        grant_reg      <= win;
        last_grant_reg <= win;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_port
      logic         pending_reg, we_reg, done_reg;
      logic [20:0]  addr_reg;
      logic [255:0] data_reg, q_reg;
      logic         mine_done;

      assign mine_done = complete && (grant_reg == 2'(gi));

      // A start while pending is dropped; pending can never be set and
      // cleared on the same edge because completion implies pending.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pending_reg <= 1'b0;
          we_reg      <= 1'b0;
          addr_reg    <= '0;
          data_reg    <= '0;
          done_reg    <= 1'b0;
          q_reg       <= '0;
        end else begin
          if (start_in[gi] && !pending_reg) begin
            pending_reg <= 1'b1;
            addr_reg    <= addr_in[gi];
            data_reg    <= data_in[gi];
            we_reg      <= we_in[gi];
          end else if (mine_done) begin
            pending_reg <= 1'b0;
          end
          done_reg <= mine_done;
          if (mine_done && !ctrl_we_reg) q_reg <= bus.ctrl_q;
        end
      end

      assign pending_vec[gi] = pending_reg;
      assign req_we[gi]      = we_reg;
      assign req_addr[gi]    = addr_reg;
      assign req_data[gi]    = data_reg;
      assign done_vec[gi]    = done_reg;
      assign q_out[gi]       = q_reg;
    end
  endgenerate

  assign bus.p0_done    = done_vec[0];
  assign bus.p1_done    = done_vec[1];
  assign bus.p2_done    = done_vec[2];
  assign bus.p0_busy    = pending_vec[0];
  assign bus.p1_busy    = pending_vec[1];
  assign bus.p2_busy    = pending_vec[2];
  assign bus.p0_q       = q_out[0];
  assign bus.p1_q       = q_out[1];
  assign bus.p2_q       = q_out[2];
  assign bus.ctrl_addr  = ctrl_addr_reg;
  assign bus.ctrl_data  = ctrl_data_reg;
  assign bus.ctrl_we    = ctrl_we_reg;
  assign bus.ctrl_start = ctrl_start_reg;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Directed and random stimulus for sdram_arbiter. A behavioural SDRAM
// controller answers commands with random latency; a queue/array reference
// model predicts grants, completion pulses, busy flags and read data.
module tb_sdram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sdram_arbiter_if bus ();
  sdram_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  localparam logic [255:0] WDATA =
    256'hDEADBEEF_CAFEBABE_01234567_89ABCDEF_00112233_44556677_8899AABB_DDEEFF00;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // controller model state
  logic done_m;
  logic done_force;
  logic slow_mode;
  logic [255:0] cmem [int];
  assign bus.ctrl_done = done_m | done_force;

  // reference model state
  logic [2:0]   m_pend;
  logic [20:0]  m_addr [3];
  logic [255:0] m_data [3];
  logic [2:0]   m_we;
  int           m_drv [3];
  logic [255:0] exp_q [3];
  logic [255:0] rmem [int];
  bit           m_inflight;
  int           m_owner, m_last, m_free, m_start_cyc;
  bit           m_cdone_prev;

  // observation records
  int obs_done_cnt [3];
  bit done_this [3];
  int last_obs_start, last_obs_cdone;
  logic [20:0] last_obs_start_addr;
  int gap_log [$];
  int grant_log [$];

  function automatic logic [255:0] init_word(int a);
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = 32'(a) * 32'h01000193 + 32'(i) * 32'h9E3779B9 + 32'h1111;
    return w;
  endfunction

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  function automatic logic [255:0] ref_read(int a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  function automatic logic get_done(int p);
    case (p)
      0: return bus.p0_done;
      1: return bus.p1_done;
      default: return bus.p2_done;
    endcase
  endfunction

  function automatic logic get_busy(int p);
    case (p)
      0: return bus.p0_busy;
      1: return bus.p1_busy;
      default: return bus.p2_busy;
    endcase
  endfunction

  function automatic logic [255:0] get_q(int p);
    case (p)
      0: return bus.p0_q;
      1: return bus.p1_q;
      default: return bus.p2_q;
    endcase
  endfunction

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural SDRAM controller: answers each ctrl_start after 1..4 cycles
  // (6 in slow mode); reset drops the outstanding command.
  initial begin : ctrl_model
    logic [20:0]  ca;
    logic [255:0] cd;
    logic         cw;
    int           lat, n;
    bit           aborted;
    done_m = 1'b0;
    bus.ctrl_q = '0;
    forever begin
      @(posedge clk);
      #1;
      done_m = 1'b0;
      if (reset && bus.ctrl_start) begin
        ca = bus.ctrl_addr;
        cd = bus.ctrl_data;
        cw = bus.ctrl_we;
        lat = slow_mode ? 6 : int'($urandom_range(1, 4));
        aborted = 1'b0;
        n = 0;
        while (n < lat && !aborted) begin
          @(posedge clk);
          #1;
          if (!reset) aborted = 1'b1;
          n++;
        end
        if (!aborted) begin
          done_m = 1'b1;
          if (cw) begin
            cmem[int'(ca)] = cd;
            bus.ctrl_q = ~cd;
          end else begin
            bus.ctrl_q = cmem.exists(int'(ca)) ? cmem[int'(ca)] : init_word(int'(ca));
          end
        end
      end
    end
  end

  task automatic do_reset_model();
    m_pend = '0;
    m_inflight = 1'b0;
    m_last = 2;
    m_free = 0;
    m_cdone_prev = 1'b0;
    last_obs_cdone = -1;
    for (int p = 0; p < 3; p++) exp_q[p] = '0;
  endtask

  task automatic request(int p, logic [20:0] a, logic [255:0] d, logic w);
    case (p)
      0: begin bus.p0_addr = a; bus.p0_data = d; bus.p0_we = w; bus.p0_start = 1'b1; end
      1: begin bus.p1_addr = a; bus.p1_data = d; bus.p1_we = w; bus.p1_start = 1'b1; end
      default: begin bus.p2_addr = a; bus.p2_data = d; bus.p2_we = w; bus.p2_start = 1'b1; end
    endcase
    if (!m_pend[p]) begin
      m_pend[p] = 1'b1;
      m_addr[p] = a;
      m_data[p] = d;
      m_we[p]   = w;
      m_drv[p]  = cyc;
    end
  endtask

  // One clock: advance to the falling edge, compare every output with the
  // model, then update the model.
  task automatic tick();
    logic [2:0] exp_done;
    int win;
    @(negedge clk);
    cyc++;
    bus.p0_start = 1'b0;
    bus.p1_start = 1'b0;
    bus.p2_start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      exp_done[p] = m_inflight && (m_owner == p) && m_cdone_prev;
      done_this[p] = get_done(p);
      if (done_this[p]) obs_done_cnt[p]++;
      chk($sformatf("p%0d_done@%0d", p, cyc), done_this[p], exp_done[p]);
    end
    if (|exp_done) begin
      if (m_we[m_owner]) rmem[int'(m_addr[m_owner])] = m_data[m_owner];
      else exp_q[m_owner] = ref_read(int'(m_addr[m_owner]));
      m_pend[m_owner] = 1'b0;
      m_inflight = 1'b0;
      m_free = cyc + 1;
    end
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("p%0d_busy@%0d", p, cyc), get_busy(p), m_pend[p]);
      chk($sformatf("p%0d_q@%0d", p, cyc), get_q(p), exp_q[p]);
    end
    if (bus.ctrl_start) begin
      if (last_obs_cdone >= 0) gap_log.push_back(cyc - last_obs_cdone);
      last_obs_start = cyc;
      last_obs_start_addr = bus.ctrl_addr;
    end
    win = -1;
    if (reset && !m_inflight && cyc >= m_free) begin
      for (int k = 1; k <= 3; k++) begin
        int p;
        p = (m_last + k) % 3;
        if (win < 0 && m_pend[p] && m_drv[p] <= cyc - 2) win = p;
      end
    end
    chk($sformatf("ctrl_start@%0d", cyc), bus.ctrl_start, win >= 0);
    if (win >= 0) begin
      chk($sformatf("ctrl_addr@%0d", cyc), bus.ctrl_addr, m_addr[win]);
      chk($sformatf("ctrl_data@%0d", cyc), bus.ctrl_data, m_data[win]);
      chk($sformatf("ctrl_we@%0d", cyc), bus.ctrl_we, m_we[win]);
      m_inflight = 1'b1;
      m_owner = win;
      m_last = win;
      m_start_cyc = cyc;
      grant_log.push_back(win);
    end else if (m_inflight) begin
      chk($sformatf("hold_addr@%0d", cyc), bus.ctrl_addr, m_addr[m_owner]);
      chk($sformatf("hold_we@%0d", cyc), bus.ctrl_we, m_we[m_owner]);
    end
    m_cdone_prev = m_inflight && bus.ctrl_done && (cyc > m_start_cyc);
    if (m_cdone_prev) last_obs_cdone = cyc;
  endtask

  task automatic wait_idle(int budget, string tag);
    int n;
    n = 0;
    while ((m_inflight || (|m_pend)) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, m_inflight || (|m_pend), 1'b0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_ctrl_start"}, bus.ctrl_start, 1'b0);
    chk({tag, "_ctrl_we"}, bus.ctrl_we, 1'b0);
    chk({tag, "_ctrl_addr"}, bus.ctrl_addr, 21'd0);
    chk({tag, "_ctrl_data"}, bus.ctrl_data, 256'd0);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("%s_p%0d_done", tag, p), get_done(p), 1'b0);
      chk($sformatf("%s_p%0d_busy", tag, p), get_busy(p), 1'b0);
      chk($sformatf("%s_p%0d_q", tag, p), get_q(p), 256'd0);
    end
  endtask

  initial begin : main
    int t0, dc, n, issued0, issued2, gsz;
    bus.p0_addr = '0; bus.p0_data = '0; bus.p0_we = 1'b0; bus.p0_start = 1'b0;
    bus.p1_addr = '0; bus.p1_data = '0; bus.p1_we = 1'b0; bus.p1_start = 1'b0;
    bus.p2_addr = '0; bus.p2_data = '0; bus.p2_we = 1'b0; bus.p2_start = 1'b0;
    done_force = 1'b0;
    slow_mode = 1'b0;
    for (int p = 0; p < 3; p++) begin
      obs_done_cnt[p] = 0;
      m_drv[p] = 0;
      m_addr[p] = '0;
      m_data[p] = '0;
    end
    m_we = '0;
    m_owner = 0;
    m_start_cyc = 0;
    last_obs_start = -1;
    last_obs_start_addr = '0;
    do_reset_model();

    // reset values
    reset = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b1;
    tick();

    // port 1 write then read at line 16
    dc = obs_done_cnt[1];
    request(1, 21'd16, WDATA, 1'b1);
    t0 = cyc;
    wait_idle(40, "t1_wr_timeout");
    chk("t1_wr_latency", last_obs_start - t0, 2);
    chk("t1_wr_done_cnt", obs_done_cnt[1] - dc, 1);
    chk("t1_wr_q_unchanged", bus.p1_q, 256'd0);
    dc = obs_done_cnt[1];
    request(1, 21'd16, 256'd0, 1'b0);
    t0 = cyc;
    wait_idle(40, "t1_rd_timeout");
    chk("t1_rd_latency", last_obs_start - t0, 2);
    chk("t1_rd_done_cnt", obs_done_cnt[1] - dc, 1);
    chk("t1_p1_q", bus.p1_q, WDATA);
    chk("t1_p0_q", bus.p0_q, 256'd0);
    chk("t1_p2_q", bus.p2_q, 256'd0);

    // simultaneous reads from reset
    reset = 1'b0;
    do_reset_model();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    grant_log.delete();
    gap_log.delete();
    request(0, 21'd0, 256'd0, 1'b0);
    request(1, 21'd8, 256'd0, 1'b0);
    request(2, 21'd24, 256'd0, 1'b0);
    wait_idle(80, "t2_timeout");
    gsz = grant_log.size();
    chk("t2_grant_cnt", gsz, 3);
    if (gsz == 3) begin
      chk("t2_grant0", grant_log[0], 0);
      chk("t2_grant1", grant_log[1], 1);
      chk("t2_grant2", grant_log[2], 2);
    end
    chk("t2_p0_q", bus.p0_q, init_word(0));
    chk("t2_p1_q", bus.p1_q, init_word(8));
    chk("t2_p2_q", bus.p2_q, init_word(24));
    chk("t2_gap_cnt", gap_log.size(), 2);
    foreach (gap_log[i]) chk($sformatf("t2_gap%0d", i), gap_log[i], 2);

    // fairness between ports 0 and 2
    grant_log.delete();
    request(0, 21'($urandom_range(0, 7) * 8), rand_word(), 1'b0);
    request(2, 21'($urandom_range(0, 7) * 8), rand_word(), 1'b0);
    issued0 = 1;
    issued2 = 1;
    n = 0;
    while ((issued0 < 6 || issued2 < 6 || m_inflight || (|m_pend)) && n < 500) begin
      tick();
      n++;
      if (done_this[0] && issued0 < 6) begin
        request(0, 21'($urandom_range(0, 7) * 8), rand_word(), 1'($urandom_range(0, 1)));
        issued0++;
      end
      if (done_this[2] && issued2 < 6) begin
        request(2, 21'($urandom_range(0, 7) * 8), rand_word(), 1'($urandom_range(0, 1)));
        issued2++;
      end
    end
    gsz = grant_log.size();
    chk("t3_grant_cnt", gsz, 12);
    if (gsz > 0) chk("t3_first", grant_log[0], 0);
    for (int i = 1; i < gsz; i++) chk($sformatf("t3_alt%0d", i), grant_log[i] == grant_log[i-1], 1'b0);

    // start while busy
    dc = obs_done_cnt[0];
    grant_log.delete();
    request(0, 21'd8, 256'd0, 1'b0);
    tick();
    chk("t4_busy", bus.p0_busy, 1'b1);
    request(0, 21'd40, 256'd0, 1'b0);
    wait_idle(40, "t4_timeout");
    repeat (4) tick();
    chk("t4_addr", last_obs_start_addr, 21'd8);
    chk("t4_done_cnt", obs_done_cnt[0] - dc, 1);
    chk("t4_grant_cnt", grant_log.size(), 1);
    chk("t4_p0_q", bus.p0_q, init_word(8));

    // reset during WAIT
    slow_mode = 1'b1;
    request(2, 21'd24, 256'd0, 1'b0);
    n = 0;
    while (!m_inflight && n < 20) begin
      tick();
      n++;
    end
    chk("t5_granted", m_inflight, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    check_reset_outputs("t5");
    do_reset_model();
    slow_mode = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    dc = obs_done_cnt[2];
    request(2, 21'd24, 256'd0, 1'b0);
    wait_idle(40, "t5_timeout");
    chk("t5_done_cnt", obs_done_cnt[2] - dc, 1);
    chk("t5_p2_q", bus.p2_q, ref_read(24));

    // spurious ctrl_done while idle
    dc = obs_done_cnt[0] + obs_done_cnt[1] + obs_done_cnt[2];
    done_force = 1'b1;
    tick();
    done_force = 1'b0;
    repeat (3) tick();
    chk("t6_done_cnt", obs_done_cnt[0] + obs_done_cnt[1] + obs_done_cnt[2] - dc, 0);
    chk("t6_p0_q", bus.p0_q, exp_q[0]);
    chk("t6_p2_q", bus.p2_q, ref_read(24));

    // random traffic
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int p = 0; p < 3; p++)
        if ($urandom_range(0, 3) == 0)
          request(p, 21'($urandom_range(0, 7) * 8), rand_word(), 1'($urandom_range(0, 1)));
    end
    wait_idle(200, "t7_drain_timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
